// File: rtl/data_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : data_frame_rx
// Brief   : AXI4-Stream receiver for fixed-length frames. Publishes good
//           frames atomically and flags short, long and partial-keep frames.
// Revision: 1.0 - initial release
// ============================================================================
module data_frame_rx #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 3,   // data_1..data_3 are the only outputs, so 3 is the only usable value
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic [DATA_W/8-1:0]   s_tkeep,
  output logic                  s_tready,
  output logic [DATA_W-1:0]     data_1,
  output logic [DATA_W-1:0]     data_2,
  output logic [DATA_W-1:0]     data_3,
  output logic                  frame_done,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_keep,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int                   c_keep_w   = DATA_W / 8;
  localparam int                   c_idx_w    = $clog2(WORDS);
  localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(WORDS - 1);
  localparam logic [c_keep_w-1:0]  c_keep_all = '1;

  typedef enum logic [0:0] {
    ST_RECV = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  state_t               r_state, w_state_n;
  logic                 r_ready;
  logic [c_idx_w-1:0]   r_idx, w_idx_n;
  logic                 r_keep_bad, w_keep_bad_n;
  logic [DATA_W-1:0]    r_stage [WORDS-1];
  logic [DATA_W-1:0]    w_stage_n [WORDS-1];
  logic [DATA_W-1:0]    r_data [WORDS];
  logic [DATA_W-1:0]    w_data_n [WORDS];
  logic                 r_done, w_done_n;
  logic                 r_short, w_short_n;
  logic                 r_long, w_long_n;
  logic                 r_keep, w_keep_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;

  logic                 w_accept;
  logic                 w_beat_bad;

  assign w_accept   = s_tvalid & r_ready;
  assign w_beat_bad = (s_tkeep != c_keep_all);

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_keep_bad_n = r_keep_bad;
    w_stage_n    = r_stage;
    w_data_n     = r_data;
    w_done_n     = 1'b0;
    w_short_n    = 1'b0;
    w_long_n     = 1'b0;
    w_keep_n     = 1'b0;
    w_cnt_n      = r_cnt;

    if (w_accept) begin
      case (r_state)
        ST_RECV: begin
          if (r_idx < c_last_idx) begin
            if (!s_tlast) begin
              for (int i = 0; i < WORDS - 1; i++) begin
                if (r_idx == c_idx_w'(i)) begin
                  w_stage_n[i] = s_tdata;
                end
              end
              w_idx_n      = r_idx + c_idx_w'(1);
              w_keep_bad_n = r_keep_bad | w_beat_bad;
            end else begin
              w_short_n    = 1'b1;
              w_keep_n     = r_keep_bad | w_beat_bad;
              w_idx_n      = '0;
              w_keep_bad_n = 1'b0;
            end
          end else if (s_tlast) begin
            w_idx_n      = '0;
            w_keep_bad_n = 1'b0;
            if (r_keep_bad | w_beat_bad) begin
              w_keep_n = 1'b1;
            end else begin
              for (int i = 0; i < WORDS - 1; i++) begin
                w_data_n[i] = r_stage[i];
              end
              w_data_n[WORDS-1] = s_tdata;
              w_done_n          = 1'b1;
              w_cnt_n           = r_cnt + CNT_W'(1);
            end
          end else begin
            // Final word without TLAST: swallow the rest of this frame.
            w_long_n  = 1'b1;
            w_state_n = ST_DROP;
            w_idx_n   = '0;
          end
        end
        ST_DROP: begin
          if (s_tlast) begin
            w_state_n    = ST_RECV;
            w_keep_bad_n = 1'b0;
          end
        end
        default: begin
          w_state_n = ST_RECV;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RECV;
      r_ready    <= 1'b0;
      r_idx      <= '0;
      r_keep_bad <= 1'b0;
      for (int i = 0; i < WORDS - 1; i++) begin
        r_stage[i] <= '0;
      end
      for (int i = 0; i < WORDS; i++) begin
        r_data[i] <= '0;
      end
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_keep     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_ready    <= 1'b1;
      r_idx      <= w_idx_n;
      r_keep_bad <= w_keep_bad_n;
      r_stage    <= w_stage_n;
      r_data     <= w_data_n;
      r_done     <= w_done_n;
      r_short    <= w_short_n;
      r_long     <= w_long_n;
      r_keep     <= w_keep_n;
      r_cnt      <= w_cnt_n;
    end
  end

  assign s_tready   = r_ready;
  assign data_1     = r_data[0];
  assign data_2     = r_data[1];
  assign data_3     = r_data[2];
  assign frame_done = r_done;
  assign err_short  = r_short;
  assign err_long   = r_long;
  assign err_keep   = r_keep;
  assign frame_cnt  = r_cnt;

endmodule
`default_nettype wire
